// File: rtl/reg_display_sequencer.sv
// Steps the register-file read address (manual or dwell-timed), latches the read
// data into a stable display word, and generates the digit-scan enable tick.
module reg_display_sequencer #(
  parameter int DWELL    = 50_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mode,
  input  logic        dir,
  input  logic        step,
  input  logic        hold,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] disp_x,
  output logic [4:0]  disp_addr,
  output logic        valid,
  output logic        scan_tick
);

  localparam int DW = $clog2(DWELL);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] SLAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {FETCH, LATCH, SHOW} state_t;

  state_t        state, state_nxt;
  logic          step_q, step_edge;
  logic [DW-1:0] dcnt;
  logic [SW-1:0] scnt;
  logic          show, latch, expire, adv;

  assign step_edge = step & ~step_q;

  // state register
  always_ff @(posedge clk) begin
    if (clr) state <= FETCH;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = SHOW;
      SHOW:    if (adv) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // outputs and datapath controls; a step edge and dwell expiry merge into one advance
  always_comb begin
    show   = (state == SHOW);
    latch  = (state == LATCH);
    valid  = show;
    expire = mode & ~hold & (dcnt == DLAST);
    adv    = show & (step_edge | expire);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q    <= 1'b1;
      rd_addr   <= '0;
      disp_addr <= '0;
      disp_x    <= '0;
      dcnt      <= '0;
    end else begin
      step_q <= step;
      if (adv) rd_addr <= dir ? rd_addr - 5'd1 : rd_addr + 5'd1;
      if (latch) begin
        disp_x    <= rd_data;
        disp_addr <= rd_addr;
      end else if (show) begin
        disp_x <= rd_data;
      end
      if (!show || !mode || adv) dcnt <= '0;
      else if (!hold)            dcnt <= dcnt + 1'b1;
    end
  end

  // tick is registered, so it lands SCAN_DIV edges after release and every SCAN_DIV after
  always_ff @(posedge clk) begin
    if (clr) begin
      scnt      <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= (scnt == SLAST);
      scnt      <= (scnt == SLAST) ? '0 : scnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_display_sequencer.sv
// Directed bench for reg_display_sequencer with a behavioural synchronous register file.
module tb_reg_display_sequencer;

  logic        clk = 1'b0;
  logic        clr, mode, dir, step, hold;
  logic [4:0]  rd_addr, disp_addr;
  logic [31:0] rd_data, disp_x;
  logic        valid, scan_tick;
  logic [31:0] rf [32];
  int          n_chk = 0;
  int          n_fail = 0;

  reg_display_sequencer #(.DWELL(4), .SCAN_DIV(3)) dut (
    .clk(clk), .clr(clr), .mode(mode), .dir(dir), .step(step), .hold(hold),
    .rd_addr(rd_addr), .rd_data(rd_data), .disp_x(disp_x),
    .disp_addr(disp_addr), .valid(valid), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rf[rd_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one step pulse: valid must be low for two cycles, then show the new register
  task automatic pulse(input logic [4:0] ea);
    logic v0, v1;
    step = 1'b1; cyc(1); v0 = valid;
    step = 1'b0; cyc(1); v1 = valid;
    cyc(1);
    chk("gap", {29'd0, v0, v1, valid}, 32'd1);
    chk("addr", 32'(disp_addr), 32'(ea));
    chk("data", disp_x, rf[ea]);
  endtask

  task automatic rst_outs(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_dispx"}, disp_x, 32'd0);
    chk({tag, "_daddr"}, 32'(disp_addr), 32'd0);
    chk({tag, "_raddr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_tick"}, 32'(scan_tick), 32'd0);
  endtask

  task automatic release_scan(input logic [31:0] d0);
    clr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      chk("scan_tick", 32'(scan_tick), 32'((k % 3) == 0));
      if (k == 1) chk("first_valid0", 32'(valid), 32'd0);
      if (k == 2) begin
        chk("first_valid1", 32'(valid), 32'd1);
        chk("first_dispx", disp_x, d0);
        chk("first_daddr", 32'(disp_addr), 32'd0);
      end
    end
  endtask

  initial begin
    clr = 1'b1; mode = 1'b0; dir = 1'b0; step = 1'b0; hold = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h11111111;
    rf[0] = 32'hDEADBEEF;

    for (int r = 0; r < 3; r++) begin
      cyc(1);
      rst_outs("rst");
    end
    release_scan(32'hDEADBEEF);

    // manual wrap up through 31 back to 0, then one step down
    rf[0] = 32'h0;
    for (int i = 1; i <= 32; i++) pulse(5'(i % 32));
    dir = 1'b1;
    pulse(5'd31);

    // live update at address 5
    dir = 1'b0;
    for (int i = 0; i <= 5; i++) pulse(5'(i));
    rf[5] = 32'h12345678;
    cyc(1); chk("live_old", disp_x, 32'h55555555);
    cyc(1); chk("live_new", disp_x, 32'h12345678);
    chk("live_valid", 32'(valid), 32'd1);

    // auto dwell: 6-cycle address period
    mode = 1'b1;
    cyc(3); chk("auto_a0", 32'(rd_addr), 32'd5);
    cyc(1); chk("auto_a1", 32'(rd_addr), 32'd6);
    chk("auto_gap", 32'(valid), 32'd0);
    cyc(2); chk("auto_daddr", 32'(disp_addr), 32'd6);
    chk("auto_dispx", disp_x, rf[6]);
    chk("auto_valid", 32'(valid), 32'd1);
    cyc(3); chk("auto_a2", 32'(rd_addr), 32'd6);
    cyc(1); chk("auto_a3", 32'(rd_addr), 32'd7);

    // hold for 10 cycles mid-dwell delays the change by 10
    cyc(4); hold = 1'b1;
    cyc(10); chk("hold_a0", 32'(rd_addr), 32'd7);
    hold = 1'b0;
    cyc(1); chk("hold_a1", 32'(rd_addr), 32'd7);
    cyc(1); chk("hold_a2", 32'(rd_addr), 32'd8);

    // step edge in FETCH is dropped
    step = 1'b1;
    cyc(1); chk("fetch_a0", 32'(rd_addr), 32'd8);
    cyc(1); chk("fetch_daddr", 32'(disp_addr), 32'd8);
    cyc(3); chk("fetch_a1", 32'(rd_addr), 32'd8);
    step = 1'b0;
    cyc(1); chk("fetch_a2", 32'(rd_addr), 32'd9);

    // step edge coinciding with dwell expiry gives one advance
    cyc(5); step = 1'b1;
    cyc(1); chk("coin_a0", 32'(rd_addr), 32'd10);
    step = 1'b0;
    cyc(2); chk("coin_daddr", 32'(disp_addr), 32'd10);
    cyc(3); chk("coin_a1", 32'(rd_addr), 32'd10);
    cyc(1); chk("coin_a2", 32'(rd_addr), 32'd11);

    // reset asserted while in LATCH
    cyc(1);
    clr = 1'b1; mode = 1'b0;
    rf[0] = 32'hCAFEF00D;
    cyc(1);
    rst_outs("midrst");
    release_scan(32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
